// File: rtl/alu_seq.sv
// alu_seq: handshaked, parametrised sequential ALU.
//
// Sits between a register-file read stage and a write-back stage. A request
// (op, r1, r2) is taken on in_valid && in_ready. The result and its status
// flags are registered and held until the consumer takes them with
// out_valid && out_ready.
//
// Most ops finish on the acceptance edge. Variable shifts with a nonzero
// amount iterate one bit per cycle. MUL iterates one shift-add step per cycle.
//
// Build option:
//   ALU_SEQ_MUL_EN - when defined, op 10 is an unsigned WIDTH x WIDTH
//                    multiply returning the low WIDTH bits.
//                    When undefined, op 10 is an illegal op and no
//                    multiplier logic is built.
//
// Parameters:
//   WIDTH  operand/result width (power of two, >= 4)
//   SHW    shift-amount width, derived from WIDTH
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_valid    request valid
//   in_ready    request accepted when in_valid && in_ready
//   op          operation code (0..10 legal, 11..15 illegal)
//   r1, r2      operands, sampled at acceptance
//   out_valid   result valid
//   out_ready   consumer takes the result when out_valid && out_ready
//   out         result
//   zero, neg, carry, ovf, err   status flags, registered together with out
//
// States:
//   S_IDLE | no result held, ready for a request
//   S_EXEC | iterating a shift or multiply, inputs ignored
//   S_DONE | result held on out until the consumer takes it
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  // The counter must be able to hold WIDTH itself, which is the MUL step count.
  localparam int unsigned CW = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_PASS = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_ASR  = 4'd9;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  typedef enum logic [1:0] {K_SHL, K_SHR, K_ASR, K_MUL} kind_e;

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
`endif

  logic             accept;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [SHW-1:0]   shamt;

  // Decoded view of the incoming request.
  logic [WIDTH-1:0] s_res;
  logic             s_c;
  logic             s_v;
  logic             s_e;
  logic             s_multi;
  kind_e            s_kind;
  logic [CW-1:0]    s_cnt;
  logic [WIDTH-1:0] s_acc;

  // One iteration of the EXEC datapath.
  logic [WIDTH-1:0] step_acc;
  logic             step_c;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  assign add_sum = {1'b0, r1} + {1'b0, r2};
  // Subtraction as r1 + ~r2 + 1, so the carry out means "no borrow".
  assign sub_sum = {1'b0, r1} + {1'b0, ~r2} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt   = r2[SHW-1:0];

  // Request decode: a single-cycle result, or the initial load for an
  // iterative op.
  always_comb begin
    s_res   = '0;
    s_c     = 1'b0;
    s_v     = 1'b0;
    s_e     = 1'b0;
    s_multi = 1'b0;
    s_kind  = K_SHL;
    s_cnt   = {1'b0, shamt};
    s_acc   = r1;
    case (op)
      OP_ADD: begin
        s_res = add_sum[WIDTH-1:0];
        s_c   = add_sum[WIDTH];
        s_v   = (r1[WIDTH-1] == r2[WIDTH-1]) && (add_sum[WIDTH-1] != r1[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = sub_sum[WIDTH-1:0];
        s_c   = sub_sum[WIDTH];
        s_v   = (r1[WIDTH-1] != r2[WIDTH-1]) && (sub_sum[WIDTH-1] != r1[WIDTH-1]);
      end
      OP_PASS: s_res = r1;
      OP_AND:  s_res = r1 & r2;
      OP_NOT:  s_res = ~r1;
      OP_OR:   s_res = r1 | r2;
      OP_XOR:  s_res = r1 ^ r2;
      OP_SHL: begin
        // A zero shift amount completes immediately with out = r1 and carry = 0.
        s_res   = r1;
        s_multi = (shamt != '0);
        s_kind  = K_SHL;
      end
      OP_SHR: begin
        s_res   = r1;
        s_multi = (shamt != '0);
        s_kind  = K_SHR;
      end
      OP_ASR: begin
        s_res   = r1;
        s_multi = (shamt != '0);
        s_kind  = K_ASR;
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        // The multiplier goes in the low accumulator and is consumed LSB first.
        s_multi = 1'b1;
        s_kind  = K_MUL;
        s_cnt   = CW'(WIDTH);
        s_acc   = r2;
      end
`endif
      default: s_e = 1'b1;
    endcase
  end

  // One step of the shifter or the shift-add multiplier.
  always_comb begin
    step_acc = acc_q;
    step_c   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mul_sum  = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    step_hi  = hi_q;
`endif
    case (kind_q)
      K_SHL: begin
        step_acc = {acc_q[WIDTH-2:0], 1'b0};
        step_c   = acc_q[WIDTH-1];
      end
      K_SHR: begin
        step_acc = {1'b0, acc_q[WIDTH-1:1]};
        step_c   = acc_q[0];
      end
      K_ASR: begin
        step_acc = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        step_c   = acc_q[0];
      end
`ifdef ALU_SEQ_MUL_EN
      K_MUL: begin
        // {hi, acc} shifts right one place. The partial sum's LSB moves into
        // the top of the low half.
        step_hi  = mul_sum[WIDTH:1];
        step_acc = {mul_sum[0], acc_q[WIDTH-1:1]};
      end
`endif
      default: ;
    endcase
  end

  // Next-state and result-register logic.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d = mcand_q;
    hi_d    = hi_q;
`endif
    if (accept) begin
      if (s_multi) begin
        state_d = S_EXEC;
        kind_d  = s_kind;
        cnt_d   = s_cnt;
        acc_d   = s_acc;
`ifdef ALU_SEQ_MUL_EN
        mcand_d = r1;
        hi_d    = '0;
`endif
      end else begin
        state_d = S_DONE;
        out_d   = s_res;
        zero_d  = (s_res == '0);
        neg_d   = s_res[WIDTH-1];
        carry_d = s_c;
        ovf_d   = s_v;
        err_d   = s_e;
      end
    end else begin
      case (state_q)
        S_EXEC: begin
          acc_d = step_acc;
          cnt_d = cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
          hi_d  = step_hi;
`endif
          // The step taken with the counter at 1 is the final one.
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            out_d   = step_acc;
            zero_d  = (step_acc == '0);
            neg_d   = step_acc[WIDTH-1];
            carry_d = (kind_q == K_MUL) ? 1'b0 : step_c;
            err_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
            ovf_d   = (kind_q == K_MUL) && (step_hi != '0);
`else
            ovf_d   = 1'b0;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        S_IDLE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      kind_q  <= K_SHL;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q <= '0;
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
`endif
    end
  end

endmodule
